topk_block_sorter: RTL and testbench
====================================

# topk_block_sorter

Streaming front end of the partial-sort (top-K) datapath. Accepts signed 16-bit samples one per cycle on a valid/ready stream, insertion-sorts them into K-element blocks, and presents each completed block as a fully sorted K*16 vector on a valid/ready output. The output feeds the sorted-block input (`desc_in` when descending) of the max-K merge stage. Double-banked so collection continues while a finished block waits downstream.

## Interface
- `K`, 8, elements per block; power of two, ≥2
- `SORTDIR`, 1, output order; 1 = descending (element 0 largest), 0 = ascending (element 0 smallest)
- `clk` in 1 — clock
- `rst` in 1 — reset, asynchronous, active-high
- `in_valid` in 1 — sample valid
- `in_ready` out 1 — sample accepted when `in_valid && in_ready`
- `in_data` in 16 — signed sample
- `in_last` in 1 — qualified by handshake; closes current block after this sample
- `out_valid` out 1 — sorted block available
- `out_ready` in 1 — downstream accepts block
- `out_data` out K*16 — sorted block; element i at bits [16*i+15:16*i], signed
- `out_count` out $clog2(K)+1 — number of real (non-pad) samples in block, 1..K

## Operation
- Two banks, B0/B1, each holding K signed registers, a fill count, and a full flag. `wr_sel` selects the filling bank; `rd_sel` selects the output bank.
- Empty bank registers hold PAD = -32768 (16'sh8000). Pad values never win a max-K selection.
- Insert: on a handshake, the sample goes into bank `wr_sel` at its sorted position, held internally descending. Registers below the insertion point shift down one slot and the last slot is dropped (it is always PAD). One insert per cycle, no stall.
- Comparison is signed. Ties are stable: a new sample goes after existing equal values.
- Block close happens when the count reaches K, or when `in_last` is accepted. The bank's full flag is set and `wr_sel` toggles.
- `in_ready` = !full[`wr_sel`]. It is low only when both banks are full.
- `out_valid` = full[`rd_sel`]. `out_data` is bank `rd_sel`, reversed combinationally when SORTDIR=0. `out_count` is that bank's count.
- On the output handshake: full[`rd_sel`] clears, the bank reloads PAD, count goes to 0, and `rd_sel` toggles.
- Output handshake and input handshake in the same cycle are legal and independent. A bank freed this cycle is fillable next cycle.
- A partial block (`in_last`) is padded with PAD. In ascending mode the pads occupy the low elements.
- `out_data`/`out_count` are held stable while `out_valid && !out_ready`.

## Timing
- Reset values: `out_valid`=0, `out_count`=0, `out_data`= all elements 16'sh8000, `in_ready`=1, `wr_sel`=`rd_sel`=0, all counts 0.
- Latency: a sample that closes a block at edge t gives `out_valid`=1 after edge t (visible in cycle t+1).
- Throughput: one sample/cycle sustained when `out_ready` is held high. No bubbles at block boundaries.
- Backpressure: after 2K samples with `out_ready`=0, `in_ready` drops. It rises the cycle after the first output handshake.
- Reset mid-block discards all contents immediately. No partial block is emitted.

## Configuration
- `TOPK_SORTER_STATS_EN` defined: adds output port `blk_count` (16 bits) and output port `pad_flag` (1 bit).
  - `blk_count` counts output handshakes and wraps from 0xFFFF to 0. Reset value is 0.
  - `pad_flag` is high while `out_valid` and `out_count` < K.
- Undefined: neither port exists and no counter logic is generated.

## Structure
- Shared package `partial_sort_pkg` holds:
  - `DATA_W`=16
  - `PAD_VAL`=16'sh8000
  - element typedef `elem_t` (signed [15:0])
  - This package is shared with the max-K and bitonic-merge stages.
- Sub-module `insert_sort_bank` contains one bank: K registers, count, full flag, insert/shift logic, and clear. It is instantiated twice.
- The top level contains the bank select, handshakes, output reversal, and stats.

## Test plan
- K=8, SORTDIR=1, feed 5,-3,7,0,7,-32768,100,2 back-to-back with `out_ready`=1 → one cycle after the 8th handshake, `out_data` elements 0..7 = 100,7,7,5,2,0,-3,-32768 and `out_count`=8.
- Same input with SORTDIR=0 → elements 0..7 = -32768,-3,0,2,5,7,7,100.
- Feed 4,9,1 with `in_last` on 1 → `out_valid` next cycle, elements 9,4,1,-32768×5, `out_count`=3.
- Hold `out_ready`=0 and stream 20 samples → `in_ready` falls after the 16th accept. Raise `out_ready` for one cycle → `in_ready`=1 next cycle, block 1 then block 2 emitted in order, no sample lost or reordered.
- Assert `rst` after 3 of 8 samples → `out_valid`=0 and `out_data` = all 16'sh8000. Next 8 samples form a clean block with no stale data.
- With `TOPK_SORTER_STATS_EN`: emit 3 blocks, the last partial → `blk_count`=3, and `pad_flag`=1 only while the partial block is valid.

Source files
------------

// File: rtl/partial_sort_pkg.sv
// Purpose: shared types and constants for the partial-sort (top-K) datapath stages.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package partial_sort_pkg;

    localparam int DATA_W = 16;

    typedef logic signed [DATA_W-1:0] elem_t;

    // Most negative sample; it never wins a max-K selection, so it doubles as filler.
    localparam elem_t PAD_VAL = 16'sh8000;

endpackage

// File: rtl/insert_sort_bank.sv
// Purpose: one K-entry insertion-sort bank, held descending (slot 0 largest).
// Latency: a sample inserted at edge t is visible in the bank registers after edge t.
// Backpressure: none internally; the caller must only insert while full is low.
//
// Ports: clk/rst; ins + din + last insert a sample (last closes the block early);
// clr empties a full bank back to PAD; regs_flat/count/full describe the contents;
// closing pulses on the insert that closes the block.
module insert_sort_bank
    import partial_sort_pkg::*;
#(
    parameter  int K     = 8,
    localparam int CNT_W = $clog2(K) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ins,
    input  elem_t                 din,
    input  logic                  last,
    input  logic                  clr,
    output logic [K*DATA_W-1:0]   regs_flat,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  closing
);

    elem_t regs [K];
    elem_t nxt  [K];
    logic  keep [K];

    // A slot keeps its value when it is occupied and >= the new sample, so equal
    // values already present stay ahead of the newcomer. Empty slots are never
    // compared, which lets a PAD-valued sample land at the fill position.
    always_comb begin
        for (int i = 0; i < K; i++) begin
            keep[i] = (CNT_W'(i) < count) && (regs[i] >= din);
        end
        nxt[0] = keep[0] ? regs[0] : din;
        for (int i = 1; i < K; i++) begin
            if (keep[i])
                nxt[i] = regs[i];
            else if (keep[i-1])
                nxt[i] = din;
            else
                nxt[i] = regs[i-1];
        end
    end

    assign closing = ins && (last || (count == CNT_W'(K - 1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K; i++) regs[i] <= PAD_VAL;
            count <= '0;
            full  <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < K; i++) regs[i] <= PAD_VAL;
            count <= '0;
            full  <= 1'b0;
        end else if (ins) begin
            for (int i = 0; i < K; i++) regs[i] <= nxt[i];
            count <= count + 1'b1;
            if (closing) full <= 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < K; i++) regs_flat[i*DATA_W +: DATA_W] = regs[i];
    end

endmodule

// File: rtl/topk_block_sorter.sv
// Purpose: streams signed samples into double-banked K-element insertion-sort blocks.
// Latency: the sample closing a block at edge t gives out_valid after edge t.
// Backpressure: in_ready drops only while both banks hold finished blocks.
//
// Ports: in_valid/in_ready/in_data/in_last sample stream; out_valid/out_ready/
// out_data/out_count sorted block stream (element i at bits [16*i+15:16*i]).
// Optional TOPK_SORTER_STATS_EN adds blk_count (output handshakes, wrapping)
// and pad_flag (valid block holds fewer than K real samples).
module topk_block_sorter
    import partial_sort_pkg::*;
#(
    parameter  int K       = 8,
    parameter  bit SORTDIR = 1'b1,
    localparam int CNT_W   = $clog2(K) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [K*DATA_W-1:0]   out_data,
    output logic [CNT_W-1:0]      out_count
`ifdef TOPK_SORTER_STATS_EN
    ,
    output logic [15:0]           blk_count,
    output logic                  pad_flag
`endif
);

    logic                 wr_sel;
    logic                 rd_sel;
    logic [1:0]           full;
    logic [1:0]           closing;
    logic [CNT_W-1:0]     cnt      [2];
    logic [K*DATA_W-1:0]  bank_dat [2];
    logic                 in_hs;
    logic                 out_hs;
    logic [K*DATA_W-1:0]  rd_dat;

    assign in_ready  = !full[wr_sel];
    assign in_hs     = in_valid && in_ready;
    assign out_valid = full[rd_sel];
    assign out_hs    = out_valid && out_ready;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        insert_sort_bank #(.K(K)) u_bank (
            .clk       (clk),
            .rst       (rst),
            .ins       (in_hs && (wr_sel == 1'(b))),
            .din       (elem_t'(in_data)),
            .last      (in_last),
            .clr       (out_hs && (rd_sel == 1'(b))),
            .regs_flat (bank_dat[b]),
            .count     (cnt[b]),
            .full      (full[b]),
            .closing   (closing[b])
        );
    end

    // Only the write bank can be inserting, so any closing pulse belongs to it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            if (|closing) wr_sel <= ~wr_sel;
            if (out_hs)   rd_sel <= ~rd_sel;
        end
    end

    // Banks are stored descending; ascending order is a pure wire reversal.
    assign rd_dat = bank_dat[rd_sel];
    always_comb begin
        out_data = rd_dat;
        if (!SORTDIR) begin
            for (int i = 0; i < K; i++)
                out_data[i*DATA_W +: DATA_W] = rd_dat[(K-1-i)*DATA_W +: DATA_W];
        end
    end

    assign out_count = cnt[rd_sel];

`ifdef TOPK_SORTER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         blk_count <= '0;
        else if (out_hs) blk_count <= blk_count + 16'd1;
    end

    assign pad_flag = out_valid && (out_count < CNT_W'(K));
`endif

endmodule

// File: tb/tb_topk_block_sorter.sv
// Purpose: directed self-checking bench for topk_block_sorter (both sort directions).
// Latency: n/a.
// Backpressure: n/a.
module tb_topk_block_sorter;

    localparam int K = 8;
    localparam int W = K * 16;
    localparam int P = -32768;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic [15:0]   in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready_d, out_valid_d, in_ready_a, out_valid_a;
    logic [W-1:0]  out_data_d, out_data_a;
    logic [3:0]    out_count_d, out_count_a;
`ifdef TOPK_SORTER_STATS_EN
    logic [15:0]   blk_count_d, blk_count_a;
    logic          pad_flag_d, pad_flag_a;
`endif

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    topk_block_sorter #(.K(K), .SORTDIR(1'b1)) u_desc (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_d),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid_d),
        .out_ready (out_ready),
        .out_data  (out_data_d),
        .out_count (out_count_d)
`ifdef TOPK_SORTER_STATS_EN
        ,
        .blk_count (blk_count_d),
        .pad_flag  (pad_flag_d)
`endif
    );

    topk_block_sorter #(.K(K), .SORTDIR(1'b0)) u_asc (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .out_data  (out_data_a),
        .out_count (out_count_a)
`ifdef TOPK_SORTER_STATS_EN
        ,
        .blk_count (blk_count_a),
        .pad_flag  (pad_flag_a)
`endif
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pk8(input int e0, input int e1, input int e2, input int e3,
                                         input int e4, input int e5, input int e6, input int e7);
        return {16'(e7), 16'(e6), 16'(e5), 16'(e4), 16'(e3), 16'(e2), 16'(e1), 16'(e0)};
    endfunction

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < K; i++) r[i*16 +: 16] = v[(K-1-i)*16 +: 16];
        return r;
    endfunction

    task automatic send(input int d, input bit last);
        in_valid = 1'b1;
        in_data  = 16'(d);
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    int s [20] = '{3, 1, 4, 1, 5, 9, 2, 6, -5, 8, -9, 7, -9, 3, 2, 3, 11, -11, 0, 11};

    logic [W-1:0] all_pad;
    logic [W-1:0] blk1, blk2, blk3;

    initial begin
        int  idx;
        bit  r;

        all_pad = pk8(P, P, P, P, P, P, P, P);
        blk1 = pk8(9, 6, 5, 4, 3, 2, 1, 1);
        blk2 = pk8(8, 7, 3, 3, 2, -5, -9, -9);
        blk3 = pk8(11, 11, 0, -11, P, P, P, P);

        // Reset state
        #12;
        check("rst_out_valid", out_valid_d, 0);
        check("rst_in_ready",  in_ready_d,  1);
        check("rst_out_count", out_count_d, 0);
        check("rst_out_data",  out_data_d,  all_pad);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full block, back-to-back, including a PAD-valued sample and a tie
        out_ready = 1'b1;
        send(5, 0); send(-3, 0); send(7, 0); send(0, 0);
        send(7, 0); send(P, 0);  send(100, 0); send(2, 0);
        check("full_valid",    out_valid_d, 1);
        check("full_desc",     out_data_d,  pk8(100, 7, 7, 5, 2, 0, -3, P));
        check("full_asc",      out_data_a,  pk8(P, -3, 0, 2, 5, 7, 7, 100));
        check("full_count",    out_count_d, 8);
`ifdef TOPK_SORTER_STATS_EN
        check("full_pad_flag", pad_flag_d, 0);
`endif
        @(posedge clk); #1;
        check("full_drained",  out_valid_d, 0);

        // Partial block closed by in_last
        send(4, 0); send(9, 0); send(1, 1);
        check("part_valid",    out_valid_d, 1);
        check("part_desc",     out_data_d,  pk8(9, 4, 1, P, P, P, P, P));
        check("part_asc",      out_data_a,  pk8(P, P, P, P, P, 1, 4, 9));
        check("part_count",    out_count_a, 3);
`ifdef TOPK_SORTER_STATS_EN
        check("part_pad_flag", pad_flag_d, 1);
`endif
        @(posedge clk); #1;
        check("part_drained",  out_valid_d, 0);
`ifdef TOPK_SORTER_STATS_EN
        check("blk_count_2",   blk_count_d, 2);
`endif

        // Backpressure: stream with out_ready low until both banks fill
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 40 && idx < 16; c++) begin
            in_valid = 1'b1;
            in_data  = 16'(s[idx]);
            r = in_ready_d;
            @(posedge clk); #1;
            if (r) idx++;
        end
        check("bp_accepts",    idx, 16);
        check("bp_in_ready",   in_ready_d, 0);
        in_data = 16'(s[16]);
        repeat (3) begin @(posedge clk); #1; end
        check("bp_stall",      in_ready_d, 0);
        check("bp_blk1_desc",  out_data_d, blk1);
        check("bp_blk1_asc",   out_data_a, rev(blk1));
`ifdef TOPK_SORTER_STATS_EN
        check("bp_pad_flag1",  pad_flag_d, 0);
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release",    in_ready_d, 1);
        check("bp_blk2_valid", out_valid_d, 1);
        check("bp_blk2_desc",  out_data_d, blk2);
        check("bp_blk2_asc",   out_data_a, rev(blk2));
        check("bp_blk2_count", out_count_d, 8);
        for (int k = 16; k < 20; k++) begin
            in_valid = 1'b1;
            in_data  = 16'(s[k]);
            in_last  = (k == 19);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_both_full",  in_ready_d, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_blk3_desc",  out_data_d, blk3);
        check("bp_blk3_asc",   out_data_a, rev(blk3));
        check("bp_blk3_count", out_count_d, 4);
`ifdef TOPK_SORTER_STATS_EN
        check("bp_pad_flag3",  pad_flag_d, 1);
`endif
        @(posedge clk); #1;
        check("bp_drained",    out_valid_d, 0);
`ifdef TOPK_SORTER_STATS_EN
        check("blk_count_5",   blk_count_d, 5);
        check("pad_flag_idle", pad_flag_d, 0);
`endif

        // Reset mid-block discards the partial contents
        send(1000, 0); send(2000, 0); send(3000, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid_d, 0);
        check("mid_rst_data",  out_data_d,  all_pad);
        check("mid_rst_ready", in_ready_d,  1);
`ifdef TOPK_SORTER_STATS_EN
        check("mid_rst_blk",   blk_count_d, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b0;
        send(10, 0); send(20, 0); send(30, 0); send(40, 0);
        send(50, 0); send(60, 0); send(70, 0); send(80, 0);
        check("post_rst_valid", out_valid_d, 1);
        check("post_rst_desc",  out_data_d, pk8(80, 70, 60, 50, 40, 30, 20, 10));
        check("post_rst_asc",   out_data_a, pk8(10, 20, 30, 40, 50, 60, 70, 80));
        check("post_rst_count", out_count_d, 8);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_drain", out_valid_d, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
